bus_responder: RTL and testbench

- Bus-side responder for the CPU byte bus. It answers the CPU's `read`, `address` and `dout` signals and drives the CPU's `din`.
- It contains an on-chip RAM, an unmapped-space default, and a small I/O page. The I/O page holds a FIFO-buffered 8N1 UART transmitter, a free-running 16-bit timer with a coherent high-byte shadow, and a scratch register.
- It sits at top level beside the CPU and is the only slave on the bus.

---
 rtl/bus_map_pkg.sv | 13 +
 rtl/uart_tx.sv | 74 +++++++
 rtl/bus_responder.sv | 70 +++++++
 tb/tb_bus_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// bus_map_pkg: I/O page offsets, STATUS bit positions and UART TX state encoding.
package bus_map_pkg;
  localparam logic [7:0] TXDATA  = 8'h00;
  localparam logic [7:0] STATUS  = 8'h01;
  localparam logic [7:0] TIMER_L = 8'h02;
  localparam logic [7:0] TIMER_H = 8'h03;
  localparam logic [7:0] SCRATCH = 8'h04;
  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVERRUN = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serializer; tx is registered and idles high.
module uart_tx
  import bus_map_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       accepted,
  output logic       tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
  tx_state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [15:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] shifter;
  logic pop, tick;
  assign empty = wptr == rptr;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign pop = state == IDLE && !empty;
  // a full FIFO still takes the byte when the shifter drains one the same cycle
  assign accepted = push && (!full || pop);
  assign busy = state != IDLE;
  assign tick = baud == 16'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pop ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && bit_cnt == 3'd7 ? STOP : DATA;
      STOP:    state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (accepted) mem[wptr[AW-1:0]] <= data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      baud    <= 16'd0;
      bit_cnt <= 3'd0;
      shifter <= 8'h00;
      tx      <= 1'b1;
    end else begin
      if (accepted) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop) rptr <= rptr + {{AW{1'b0}}, 1'b1};
      baud <= (state == IDLE || tick) ? RELOAD : baud - 16'd1;
      if (pop) begin
        shifter <= mem[rptr[AW-1:0]];
        tx      <= 1'b0;
      end else if (tick && state == START) begin
        tx      <= shifter[0];
        shifter <= shifter >> 1;
        bit_cnt <= 3'd0;
      end else if (tick && state == DATA) begin
        tx      <= bit_cnt == 3'd7 ? 1'b1 : shifter[0];
        shifter <= shifter >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
endmodule

// File: rtl/bus_responder.sv
// bus_responder: sole CPU bus slave with RAM, unmapped 0xFF default and an I/O page
// holding a UART transmitter, a free-running timer with high-byte shadow and a scratch byte.
module bus_responder
  import bus_map_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter logic [7:0]  IO_PAGE    = 8'hFF,
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        tx
);
  logic [7:0] ram [2**RAM_AW];
  logic [15:0] timer;
  logic [7:0] shadow, scratch, offset, status, io_data, rdata;
  logic overrun, io_sel, ram_sel, wr_io, push, full, empty, busy, accepted;
  assign offset = address[7:0];
  assign io_sel = address[15:8] == IO_PAGE;
  assign ram_sel = !io_sel && (address >> RAM_AW) == 16'd0;
  assign wr_io = !read && io_sel;
  assign push = wr_io && offset == TXDATA;
  always_comb begin
    status = 8'h00;
    status[ST_BUSY] = busy;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVERRUN] = overrun;
    io_data = offset == STATUS  ? status :
              offset == TIMER_L ? timer[7:0] :
              offset == TIMER_H ? shadow :
              offset == SCRATCH ? scratch : 8'h00;
    rdata = io_sel ? io_data : ram_sel ? ram[address[RAM_AW-1:0]] : 8'hFF;
  end
  always_ff @(posedge clk)
    if (!read && ram_sel) ram[address[RAM_AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout    <= 8'h00;
      timer   <= 16'd0;
      shadow  <= 8'h00;
      scratch <= 8'h00;
      overrun <= 1'b0;
    end else begin
      timer <= timer + 16'd1;
      if (read) dout <= rdata;
      if (read && io_sel && offset == TIMER_L) shadow <= timer[15:8];
      if (wr_io && offset == SCRATCH) scratch <= din;
      // a new overrun beats a simultaneous clear
      overrun <= push && !accepted ? 1'b1 :
                 wr_io && offset == STATUS && din[ST_OVERRUN] ? 1'b0 : overrun;
    end
  uart_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk),
    .rst(rst),
    .push(push),
    .data(din),
    .full(full),
    .empty(empty),
    .busy(busy),
    .accepted(accepted),
    .tx(tx)
  );
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed vectors with hand-computed expectations for bus_responder.
module tb_bus_responder;
  logic clk = 1'b0;
  logic rst, read, tx;
  logic [15:0] address;
  logic [7:0] din, dout;
  int checks = 0, errors = 0;
  logic [8:0] rx_q[$];
  logic [7:0] mon_byte;
  logic mon_en = 1'b1;
  logic [39:0] got_frame;
  logic lo;

  bus_responder #(.BAUD_DIV(4)) dut (
    .clk(clk), .rst(rst), .read(read), .address(address),
    .din(din), .dout(dout), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    read = 1'b0; address = a; din = d;
    @(negedge clk);
    read = 1'b1; address = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    read = 1'b1; address = a;
    @(negedge clk);
    check(tag, dout, exp);
    address = 16'h0000;
  endtask

  // 4-clk start, 8 data bits LSB first at 4 clks each, 4-clk stop
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    for (int i = 0; i < 40; i++)
      frame_bits[i] = i < 4 ? 1'b0 : i < 36 ? b[(i - 4) / 4] : 1'b1;
  endfunction

  // serial receiver: samples mid-bit, queues {stop, data}
  initial forever begin
    @(negedge clk);
    if (rst && mon_en && tx == 1'b0) begin
      repeat (5) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        mon_byte[j] = tx;
        if (j < 7) repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      rx_q.push_back({tx, mon_byte});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; read = 1'b1; address = 16'h0000; din = 8'h00;
    @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_tx", tx, 1'b1);
    rst = 1'b1;
    rd("rst_status", 16'hFF01, 8'h04);
    rd("rst_scratch", 16'hFF04, 8'h00);

    wr(16'h0010, 8'hA5);
    wr(16'h0011, 8'h5A);
    rd("ram_10", 16'h0010, 8'hA5);
    rd("ram_11", 16'h0011, 8'h5A);

    wr(16'h0000, 8'h77);
    wr(16'hFF04, 8'h3C);
    rd("scratch", 16'hFF04, 8'h3C);
    rd("unmapped_rd", 16'h8000, 8'hFF);
    wr(16'h8000, 8'h12);
    rd("unmapped_scratch", 16'hFF04, 8'h3C);
    rd("unmapped_status", 16'hFF01, 8'h04);
    rd("unmapped_ram0", 16'h0000, 8'h77);
    rd("io_other", 16'hFF07, 8'h00);
    rd("txdata_rd", 16'hFF00, 8'h00);
    rd("timer_h_wr_before", 16'hFF03, 8'h00);

    wr(16'hFF00, 8'h55);
    for (int i = 0; i < 40; i++) begin
      address = (i == 20) ? 16'hFF01 : 16'h0000;
      @(negedge clk);
      got_frame[i] = tx;
      if (i == 20) check("status_mid", dout, 8'h05);
    end
    address = 16'h0000;
    check("frame_55", got_frame, frame_bits(8'h55));
    @(negedge clk);
    rd("status_after", 16'hFF01, 8'h04);
    check("rx_55_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rx_55", rx_q[0], 9'h155);
    rx_q.delete();

    for (int i = 1; i <= 6; i++) wr(16'hFF00, 8'(i));
    rd("status_ovr", 16'hFF01, 8'h0B);
    wr(16'hFF01, 8'h08);
    rd("status_clr", 16'hFF01, 8'h03);
    for (int i = 0; i < 400 && rx_q.size() < 5; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    check("ovr_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check($sformatf("ovr_rx%0d", i), rx_q[i], {1'b1, 8'(i + 1)});
    rd("ovr_status_end", 16'hFF01, 8'h04);

    mon_en = 1'b0;
    wr(16'hFF04, 8'h99);
    wr(16'hFF00, 8'h00);
    wr(16'hFF00, 8'h00);
    repeat (6) @(negedge clk);
    check("mid_tx_pre", tx, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_dout", dout, 8'h00);
    @(negedge clk);
    read = 1'b1; address = 16'hFF02;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_timer_l", dout, 8'h00);
    rd("mid_status", 16'hFF01, 8'h04);
    rd("mid_scratch", 16'hFF04, 8'h00);
    lo = 1'b0;
    repeat (20) begin
      @(negedge clk);
      lo |= !tx;
    end
    check("mid_tx_idle", lo, 1'b0);

    rst = 1'b0; read = 1'b1; address = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (511) @(posedge clk);
    @(negedge clk);
    address = 16'hFF02;
    @(negedge clk);
    check("timer_l_1ff", dout, 8'hFF);
    address = 16'h0000;
    @(negedge clk);
    address = 16'hFF03;
    @(negedge clk);
    check("timer_h_shadow", dout, 8'h01);
    address = 16'h0000;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
